// File: rtl/neuron_mac_engine_if.sv
// Beat/result bundle between the memory read sequencer and neuron_mac_engine.
interface neuron_mac_engine_if #(
    parameter int DATA_WIDTH       = 24,
    parameter int Weight_Percision = 5,
    parameter int ACC_W            = 42
);
    logic                        start;
    logic [DATA_WIDTH-1:0]       b;
    logic                        in_valid;
    logic [DATA_WIDTH-1:0]       x;
    logic [Weight_Percision-1:0] w;
    logic                        last;
    logic                        in_ready;
    logic                        busy;
    logic                        result_valid;
    logic                        cat_out;
    logic [ACC_W-1:0]            acc_out;
    logic                        overrun;

    // A beat (x, w, last) transfers on a rising edge where in_valid & in_ready;
    // the master holds the beat stable until that edge, and in_valid carries no
    // meaning while in_ready is low.
    modport master (
        output start, b, in_valid, x, w, last,
        input  in_ready, busy, result_valid, cat_out, acc_out, overrun
    );

    modport slave (
        input  start, b, in_valid, x, w, last,
        output in_ready, busy, result_valid, cat_out, acc_out, overrun
    );
endinterface

// File: rtl/neuron_mac_engine.sv
// Bias-preloaded signed multiply-accumulate with a registered cat/no-cat decision.
// Define NEURON_MAC_PIPE_EN to register the product before the adder (adds PIPE_FLUSH).
module neuron_mac_engine #(
    parameter int DATA_WIDTH       = 24,
    parameter int Addr_Depth       = 12,
    parameter int Weight_Percision = 5,
    parameter int ACC_W            = DATA_WIDTH + Weight_Percision + Addr_Depth + 1
) (
    input  logic               clk,
    input  logic               rst,
    neuron_mac_engine_if.slave bus,
    output logic [1:0]         dbg_state
);
    localparam int PROD_W = DATA_WIDTH + Weight_Percision + 1;
    localparam logic [Addr_Depth-1:0] CNT_ONE = {{(Addr_Depth-1){1'b0}}, 1'b1};

`ifdef NEURON_MAC_PIPE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2, PIPE_FLUSH = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [Addr_Depth-1:0]   cnt_q;
    logic                    in_ready_q;
    logic                    busy_q;
    logic                    result_valid_q;
    logic                    cat_out_q;
    logic [ACC_W-1:0]        acc_out_q;
    logic                    overrun_q;

    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic                     accept;
    logic                     term;

`ifdef NEURON_MAC_PIPE_EN
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  prod_q_ext;
`endif

    // Pixel is unsigned: zero-extend it so the signed multiply never sees a sign bit.
    always_comb begin
        x_ext    = $signed({{(Weight_Percision + 1){1'b0}}, bus.x});
        w_ext    = $signed({{(PROD_W - Weight_Percision){bus.w[Weight_Percision-1]}}, bus.w});
        prod     = x_ext * w_ext;
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        bias_ext = {{(ACC_W - DATA_WIDTH){bus.b[DATA_WIDTH-1]}}, bus.b};
        accept   = bus.in_valid & in_ready_q;
        // The all-ones count marks the N_MAX-th beat, which ends the run even without last.
        term     = accept & (bus.last | (cnt_q == {Addr_Depth{1'b1}}));
    end

`ifdef NEURON_MAC_PIPE_EN
    always_comb begin
        prod_q_ext = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            cat_out_q      <= 1'b0;
            acc_out_q      <= '0;
            overrun_q      <= 1'b0;
`ifdef NEURON_MAC_PIPE_EN
            prod_q         <= '0;
`endif
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= ACCUM;
                        acc_q      <= bias_ext;
                        cnt_q      <= '0;
                        overrun_q  <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
`ifdef NEURON_MAC_PIPE_EN
                        prod_q     <= '0;
`endif
                    end
                end
                ACCUM: begin
`ifdef NEURON_MAC_PIPE_EN
                    // Gaps load a zero product, so the add can run every cycle.
                    acc_q  <= acc_q + prod_q_ext;
                    prod_q <= accept ? prod : '0;
`else
                    if (accept) acc_q <= acc_q + prod_ext;
`endif
                    if (accept) cnt_q <= cnt_q + CNT_ONE;
                    if (term) begin
                        in_ready_q <= 1'b0;
                        overrun_q  <= ~bus.last;
`ifdef NEURON_MAC_PIPE_EN
                        state_q    <= PIPE_FLUSH;
`else
                        state_q    <= DONE;
`endif
                    end
                end
`ifdef NEURON_MAC_PIPE_EN
                PIPE_FLUSH: begin
                    acc_q   <= acc_q + prod_q_ext;
                    prod_q  <= '0;
                    state_q <= DONE;
                end
`endif
                DONE: begin
                    result_valid_q <= 1'b1;
                    acc_out_q      <= acc_q;
                    cat_out_q      <= ~acc_q[ACC_W-1] & (acc_q != '0);
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.cat_out      = cat_out_q;
    assign bus.acc_out      = acc_out_q;
    assign bus.overrun      = overrun_q;
    assign dbg_state        = state_q;
endmodule

// File: doc/neuron_mac_engine.md
Name: neuron_mac_engine

Overview:
- Downstream compute stage of the cat recognizer datapath. It consumes the pixel words read from the pixel register file and the signed weights read from the weight memory, one pair per beat.
- Each accepted pair is multiplied and added into a wide signed accumulator that is preloaded with the bias at start.
- After the last beat it drives a registered cat/no-cat decision (accumulator > 0) with a one-cycle result strobe.
- Sits between the memory read sequencer (which supplies start, beats and last) and the CatRecOut output pin.

Parameters:
- DATA_WIDTH, 24, width of pixel word x and bias b (Amba_Word)
- Addr_Depth, 12, log2 of the maximum beat count per classification (N_MAX = 2^Addr_Depth = 4096)
- Weight_Percision, 5, width of the signed two's-complement weight w
- ACC_W, DATA_WIDTH+Weight_Percision+Addr_Depth+1 (=42), accumulator width; cannot overflow for N_MAX beats plus bias

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a classification, sampled only in IDLE
- b  in  DATA_WIDTH  signed bias, sampled on the accepted start edge
- in_valid  in  1  beat valid
- x  in  DATA_WIDTH  unsigned pixel word
- w  in  Weight_Percision  signed weight
- last  in  1  marks the final beat, qualified by in_valid & in_ready
- in_ready  out  1  engine accepts a beat this cycle
- busy  out  1  high in any state other than IDLE
- result_valid  out  1  one-cycle strobe; result registers updated
- cat_out  out  1  decision: 1 iff final accumulator > 0 (strictly)
- acc_out  out  ACC_W  final signed accumulator value
- overrun  out  1  run was terminated at N_MAX beats without last

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - Reset is asynchronous and active-low on rst.
  - While rst = 0, all outputs and state are 0: state IDLE, in_ready = 0, busy = 0, result_valid = 0, cat_out = 0, acc_out = 0, overrun = 0, beat count = 0, accumulator = 0.
  - Reset asserted mid-run aborts the run immediately. No result strobe is produced.
- States: IDLE, ACCUM, DONE (plus PIPE_FLUSH, only when the optional feature is compiled in).
- IDLE:
  - in_ready = 0; in_valid is ignored.
  - start = 1 at edge k: accumulator <= sign-extended b, count <= 0, overrun <= 0, state <= ACCUM.
  - cat_out and acc_out keep their previous values until the next DONE.
- ACCUM:
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready at an edge. On acceptance: acc <= acc + ({1'b0, x} * sign-extended w), computed as a signed multiply; count <= count + 1.
  - in_valid = 0 cycles (gaps) hold all state.
  - start is ignored in every state except IDLE.
- Leaving ACCUM:
  - An accepted beat with last = 1 moves to DONE.
  - An accepted beat that is the N_MAX-th beat with last = 0 also moves to DONE and sets overrun <= 1.
  - If the N_MAX-th beat also carries last = 1, overrun stays 0.
- DONE (exactly one cycle, then IDLE):
  - result_valid = 1.
  - acc_out = final accumulator, which includes the last beat.
  - cat_out = (acc_out > 0).
  - in_ready = 0.
- Latency:
  - Last beat accepted at edge k → result_valid high in the cycle between edges k+1 and k+2.
  - acc_out, cat_out and overrun are stable from that cycle until the next DONE.
- start in the DONE cycle is ignored. A new start is accepted from IDLE on the following cycle at the earliest.
- Zero-beat run is impossible: at least one beat is required before DONE can be reached.

Optional Feature:
- Macro: NEURON_MAC_PIPE_EN.
- Defined:
  - A product register sits between the multiplier and the adder.
  - The product of a beat accepted at edge k is added at edge k+1.
  - After the terminating beat the FSM passes ACCUM → PIPE_FLUSH (1 cycle, in_ready = 0) → DONE.
  - Result latency is therefore one cycle longer than without the macro.
  - The product register is cleared by reset and on start.
- Undefined: single-cycle multiply-accumulate as described in Behaviour; the PIPE_FLUSH state does not exist.

Test Plan:
- Reset: drive rst = 0 during ACCUM after 2 beats, then release → busy = 0, in_ready = 0, result_valid never pulses, acc_out = 0, cat_out = 0.
- Positive result: start with b = 0; beats (x,w) = (10,1), (20,-2), (30,3), last on the third, with a 2-cycle in_valid gap → one result_valid pulse, acc_out = 60, cat_out = 1, overrun = 0.
- Negative bias: b = 0xFFFF9C (-100); one beat x = 5, w = 15, last → acc_out = -25, cat_out = 0. A start pulse during ACCUM is ignored.
- Zero boundary: b = 0; x = 7, w = 0, last → acc_out = 0, cat_out = 0 (strictly greater-than).
- Overrun at maximum magnitude: b = 0; 4096 beats x = 0xFFFFFF, w = -16, last never set → DONE after the 4096th beat, overrun = 1, acc_out = -16*16777215*4096 (no wrap), cat_out = 0. Beat 4097 is not accepted.
- Latency check: run the positive-result case with and without NEURON_MAC_PIPE_EN → result_valid 1 cycle after the last-beat edge without the macro, 2 cycles with it; acc_out = 60 in both builds.
